sm_regdata_uart: RTL
====================

# sm_regdata_uart

Serial reporter downstream of `sm_top`: captures the 32-bit `regData` word the core exposes for the selected `regAddr`, and transmits it as 8 uppercase ASCII hex digits followed by CR LF over an 8N1 UART line. Lets a bench or board observe core register contents with one pin. It runs on the same divided `clk` that `sm_top` drives out.

## Interface

- `BAUD_DIV`, default 87: clock cycles per UART bit; legal range 2..65535.

- `clk` in 1: system clock; the `sm_top` `clk` output.
- `rst_p` in 1: reset, synchronous, active-high.
- `regData` in 32: word to report, from `sm_top.regData`.
- `send` in 1: request one transmission; sampled every cycle.
- `autoSend` in 1: when high, transmit automatically whenever `regData` differs from the last word sent.
- `tx` out 1: UART line; idles high.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse when the final stop bit completes.

## Operation

- States: IDLE, START, DATA, STOP. Registers:
  - `shadow[31:0]`: captured word.
  - `lastSent[31:0]` and `lastValid`.
  - `charIdx` 0..9.
  - `bitIdx` 0..7.
  - `baudCnt[15:0]`.
  - `txByte[7:0]`.
- Trigger in IDLE: `send`=1, or (`autoSend`=1 and (`lastValid`=0 or `regData`≠`lastSent`)). On trigger:
  - `shadow` ← `regData`, `lastSent` ← `regData`, `lastValid` ← 1.
  - `charIdx` ← 0, `baudCnt` ← 0; go to START.
- Character `charIdx` k:
  - k=0..7: nibble `shadow[31-4k -: 4]`, MSB nibble first. 0–9 encode as 0x30+n; A–F encode as 0x37+n.
  - k=8: 0x0D. k=9: 0x0A.
- Bit line levels:
  - START: `tx`=0.
  - DATA: `tx`=`txByte[bitIdx]`, LSB first.
  - STOP: `tx`=1.
- Bit pacing: each state/bit holds for exactly `BAUD_DIV` cycles.
  - `baudCnt` counts 0..`BAUD_DIV`-1. The terminal count advances the bit.
  - DATA leaves after `bitIdx`=7.
  - STOP leaves to START (`charIdx`+1) if `charIdx`<9, else to IDLE with `done`.
- Each character is 10 bits, so a full frame is 100·`BAUD_DIV` cycles with no inter-character gap.
- `send` or a `regData` change while busy is ignored, not queued.
  - `regData` changes mid-frame do not affect the frame, which uses `shadow`.
  - With `autoSend`=1, a change during a frame is picked up on the first IDLE cycle after it, because the comparison is against `lastSent`.
- `send` and an `autoSend` trigger in the same cycle start one frame only.

## Timing

- Reset values:
  - `tx`=1, `busy`=0, `done`=0.
  - state IDLE, `lastValid`=0, `lastSent`=0, all counters 0.
- All outputs are registered.
- Trigger sampled in cycle N: `tx`=0 and `busy`=1 from cycle N+1.
- Start bit of character k begins at cycle N+1+10·k·`BAUD_DIV`.
- Final stop bit occupies cycles N+1+99·`BAUD_DIV` … N+100·`BAUD_DIV`.
- At cycle N+100·`BAUD_DIV`+1:
  - `busy`=0 and `done`=1 for one cycle.
  - The state is IDLE, so a trigger sampled in this cycle starts the next frame at the following cycle. The back-to-back period is 100·`BAUD_DIV`+1 cycles.
- `rst_p` mid-frame: next cycle `tx`=1, `busy`=0, no `done` pulse, `lastValid`=0.

## Test plan

- Reset: hold `rst_p`=1 for 3 cycles, then check `tx`=1, `busy`=0, `done`=0. With `autoSend`=0 and `send`=0, all outputs stay unchanged for 1000 cycles.
- `BAUD_DIV`=4, `regData`=0x1234ABCD, 1-cycle `send` → decoded bytes 0x31 0x32 0x33 0x34 0x41 0x42 0x43 0x44 0x0D 0x0A. `busy` is high exactly 400 cycles, then a single `done` pulse.
- `BAUD_DIV`=4, `regData`=0x0000000F, `send` pulsed at cycles 10 and 200 after the trigger → exactly one frame "0000000F\r\n"; the second pulse is ignored.
- `BAUD_DIV`=2, `autoSend`=1: `regData`=5 → frame "00000005\r\n". Then set `regData`=7 at cycle 50 of that frame → the first frame is unaltered, and a second frame "00000007\r\n" starts 1 cycle after `done`. Holding `regData` stable produces no third frame.
- `BAUD_DIV`=4: assert `rst_p` 150 cycles into a frame → `tx`=1 and `busy`=0 the next cycle, no `done`. With `autoSend`=1, the frame restarts after reset release because `lastValid` was cleared.
- `BAUD_DIV`=65535, `regData`=0xFFFFFFFF → first start bit lasts exactly 65535 cycles; the first character received is 0x46 ('F').

Source files
------------

// File: rtl/sm_regdata_uart.sv
// Serial register reporter: sends a captured 32-bit word as 8 uppercase ASCII hex digits
// followed by CR LF on an 8N1 UART line, BAUD_DIV clocks per bit.
module sm_regdata_uart #(
    parameter int BAUD_DIV = 87
) (
    input  logic        clk,
    input  logic        rst_p,
    input  logic [31:0] regData,
    input  logic        send,
    input  logic        autoSend,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [3:0]  LAST_CHAR = 4'd9;

    // Character idx of the frame: hex digits 0..7 MSB nibble first, then CR, then LF.
    function automatic logic [7:0] char_of(input logic [3:0] idx, input logic [31:0] word);
        logic [31:0] shifted;
        logic [3:0]  nib;
        shifted = word << {idx[2:0], 2'b00};
        nib     = shifted[31:28];
        if (idx == 4'd8)
            char_of = 8'h0D;
        else if (idx == 4'd9)
            char_of = 8'h0A;
        else if (nib < 4'd10)
            char_of = 8'h30 + {4'h0, nib};
        else
            char_of = 8'h37 + {4'h0, nib};
    endfunction

    state_t      state_q, state_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] last_sent_q, last_sent_d;
    logic        last_valid_q, last_valid_d;
    logic [3:0]  char_idx_q, char_idx_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        baud_end;
    logic        trigger;

    assign baud_end = (baud_cnt_q == BAUD_LAST);
    // Auto mode compares against the last word sent, so changes during a frame are not lost.
    assign trigger  = send | (autoSend & (~last_valid_q | (regData != last_sent_q)));

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        last_sent_d  = last_sent_q;
        last_valid_d = last_valid_q;
        char_idx_d   = char_idx_q;
        bit_idx_d    = bit_idx_q;
        baud_cnt_d   = baud_cnt_q;
        tx_byte_d    = tx_byte_q;
        tx_d         = tx_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    shadow_d     = regData;
                    last_sent_d  = regData;
                    last_valid_d = 1'b1;
                    char_idx_d   = 4'd0;
                    bit_idx_d    = 3'd0;
                    baud_cnt_d   = 16'd0;
                    tx_byte_d    = char_of(4'd0, regData);
                    state_d      = START;
                    tx_d         = 1'b0;
                    busy_d       = 1'b1;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_cnt_d = 16'd0;
                    bit_idx_d  = 3'd0;
                    state_d    = DATA;
                    tx_d       = tx_byte_q[0];
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_cnt_d = 16'd0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = tx_byte_q[bit_idx_q + 3'd1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_cnt_d = 16'd0;
                    if (char_idx_q < LAST_CHAR) begin
                        char_idx_d = char_idx_q + 4'd1;
                        tx_byte_d  = char_of(char_idx_q + 4'd1, shadow_q);
                        state_d    = START;
                        tx_d       = 1'b0;
                    end else begin
                        char_idx_d = 4'd0;
                        state_d    = IDLE;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            state_q      <= IDLE;
            last_sent_q  <= 32'd0;
            last_valid_q <= 1'b0;
            char_idx_q   <= 4'd0;
            bit_idx_q    <= 3'd0;
            baud_cnt_q   <= 16'd0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_sent_q  <= last_sent_d;
            last_valid_q <= last_valid_d;
            char_idx_q   <= char_idx_d;
            bit_idx_q    <= bit_idx_d;
            baud_cnt_q   <= baud_cnt_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Payload registers are always loaded before use, so they carry no reset.
    always_ff @(posedge clk) begin
        shadow_q  <= shadow_d;
        tx_byte_q <= tx_byte_d;
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
